// File: rtl/elevator_car_ctrl.sv
// SCAN elevator car controller: latches floor calls, steps the car on slow-tick events, times the door.
// Optional macro ELEVATOR_ESTOP_EN adds an estop input that freezes motion/door timing and holds the car in IDLE.
module elevator_car_ctrl #(
  parameter int FLOORS     = 8,
  parameter int FLOOR_W    = 3,
  parameter int MOVE_TICKS = 2,
  parameter int DOOR_TICKS = 3
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               tick,
  input  logic [FLOORS-1:0]  req,
`ifdef ELEVATOR_ESTOP_EN
  input  logic               estop,
`endif
  output logic [FLOOR_W-1:0] floor,
  output logic               dir_up,
  output logic               moving,
  output logic               door_open,
  output logic [FLOORS-1:0]  pending
);

  localparam int CNT_MAX = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t              state_q, state_d;
  logic [FLOOR_W-1:0]  floor_q, floor_d;
  logic                dir_up_q, dir_up_d;
  logic                moving_q, moving_d;
  logic                door_open_q, door_open_d;
  logic [FLOORS-1:0]   pending_q, pending_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tick_s1_q, tick_s1_d;
  logic                tick_s2_q, tick_s2_d;
  logic                tick_s3_q, tick_s3_d;
  logic                tick_evt_q, tick_evt_d;

  logic                freeze;
  logic                evt;
  logic [FLOORS-1:0]   clr;
  logic [FLOORS-1:0]   above_mask;
  logic [FLOORS-1:0]   below_mask;
  logic                any_above;
  logic                any_below;
  logic [FLOORS-1:0]   floor_onehot;

`ifdef ELEVATOR_ESTOP_EN
  assign freeze = estop;
`else
  assign freeze = 1'b0;
`endif

  assign evt          = tick_evt_q & ~freeze;
  assign floor_onehot = {{(FLOORS-1){1'b0}}, 1'b1} << floor_q;

  // Two-flop synchroniser, then a registered rising-edge detect on the slow tick.
  always_comb begin
    tick_s1_d  = tick;
    tick_s2_d  = tick_s1_q;
    tick_s3_d  = tick_s2_q;
    tick_evt_d = tick_s2_q & ~tick_s3_q;
  end

  always_comb begin
    above_mask = '0;
    below_mask = '0;
    for (int i = 0; i < FLOORS; i++) begin
      above_mask[i] = (i > int'(floor_q));
      below_mask[i] = (i < int'(floor_q));
    end
    any_above = |(pending_q & above_mask);
    any_below = |(pending_q & below_mask);
  end

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_up_d = dir_up_q;
    cnt_d    = cnt_q;
    clr      = '0;
    unique case (state_q)
      IDLE: begin
        if (!freeze) begin
          if (pending_q[floor_q]) begin
            state_d = DOOR;
            clr     = floor_onehot;
            cnt_d   = '0;
          end else if ((dir_up_q && any_above) || (!dir_up_q && any_below)) begin
            state_d = MOVE;
            cnt_d   = '0;
          end else if (any_above || any_below) begin
            dir_up_d = ~dir_up_q;
            state_d  = MOVE;
            cnt_d    = '0;
          end
        end
      end
      MOVE: begin
        if (evt) begin
          if (cnt_q == CNT_W'(MOVE_TICKS - 1)) begin
            floor_d = dir_up_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DOOR: begin
        // The car is at this floor with the door open, so a fresh call here is serviced by extending the door.
        clr = floor_onehot;
        if (req[floor_q]) begin
          cnt_d = '0;
        end else if (evt) begin
          if (cnt_q == CNT_W'(DOOR_TICKS - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    pending_d   = (pending_q | req) & ~clr;
    moving_d    = (state_d == MOVE);
    door_open_d = (state_d == DOOR);
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      floor_q     <= '0;
      dir_up_q    <= 1'b1;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
      pending_q   <= '0;
      cnt_q       <= '0;
      tick_s1_q   <= 1'b0;
      tick_s2_q   <= 1'b0;
      tick_s3_q   <= 1'b0;
      tick_evt_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      dir_up_q    <= dir_up_d;
      moving_q    <= moving_d;
      door_open_q <= door_open_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      tick_s1_q   <= tick_s1_d;
      tick_s2_q   <= tick_s2_d;
      tick_s3_q   <= tick_s3_d;
      tick_evt_q  <= tick_evt_d;
    end
  end

  assign floor     = floor_q;
  assign dir_up    = dir_up_q;
  assign moving    = moving_q;
  assign door_open = door_open_q;
  assign pending   = pending_q;

endmodule
